// File: rtl/md5_result_reader_pkg.sv
// Shared definitions for the md5 result reader: thread-state encodings,
// reader FSM states and the optional result header layout.
package md5_result_reader_pkg;

    localparam int unsigned THREAD_STATE_MSB = 2;
    typedef logic [THREAD_STATE_MSB:0] thread_state_t;

    localparam thread_state_t THREAD_STATE_NONE    = 3'd0;
    localparam thread_state_t THREAD_STATE_PROCB   = 3'd1;
    localparam thread_state_t THREAD_STATE_RUNNING = 3'd2;
    localparam thread_state_t THREAD_STATE_WR_RDY  = 3'd3;

    typedef enum logic [2:0] {
        StScan,
        StCheck,
        StLookup,
        StRead,
        StDrain,
        StRelease
    } resread_state_e;

    // Header: {16'h0, thread (8b), 5'b0, save_len (3b)}; len arrives zero-extended.
    function automatic logic [31:0] header_word(input logic [7:0] thread,
                                                input logic [7:0] len);
        return {16'h0, thread, len};
    endfunction

endpackage

// File: rtl/md5_result_reader_outbuf.sv
// Two-entry output FIFO holding {last, thread, data}. The parent guarantees
// via credits that push never happens while full.
module md5_result_reader_outbuf #(
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == 2'd0);
    assign full    = (count_q == 2'd2);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/md5_result_reader.sv
// Drains finished md5 results: finds WR_RDY threads round-robin, reads their
// result words from memory and streams them out. Optional header: RESULT_HEADER_EN.
module md5_result_reader
    import md5_result_reader_pkg::*;
#(
    parameter int unsigned N_THREADS     = 12,
    parameter int unsigned MEM_ADDR_MSB  = 4,
    parameter int unsigned SAVE_LEN_W    = 3,
    localparam int unsigned N_THREADS_MSB = $clog2(N_THREADS) - 1
) (
    input  logic                                 CLK,
    input  logic                                 RST_N,
    output logic [N_THREADS_MSB:0]               ts_rd_num,
    input  logic [THREAD_STATE_MSB:0]            ts_rd,
    output logic [N_THREADS_MSB:0]               ts_wr_num,
    output logic [THREAD_STATE_MSB:0]            ts_wr,
    output logic                                 ts_wr_en,
    output logic [N_THREADS_MSB:0]               save_rd_num,
    input  logic [MEM_ADDR_MSB+SAVE_LEN_W:0]     save_rd,
    output logic                                 mem_rd_req,
    output logic [MEM_ADDR_MSB:0]                mem_rd_addr,
    input  logic                                 mem_rd_grant,
    input  logic [31:0]                          mem_dout,
    input  logic                                 mem_dout_en,
    output logic [31:0]                          dout,
    output logic                                 dout_valid,
    input  logic                                 dout_ready,
    output logic                                 dout_last,
    output logic [N_THREADS_MSB:0]               dout_thread
);

    localparam int unsigned ENTRY_W = 1 + N_THREADS_MSB + 1 + 32;
    localparam logic [N_THREADS_MSB:0] LAST_THREAD = (N_THREADS_MSB + 1)'(N_THREADS - 1);

    resread_state_e             state_q, state_d;
    logic [N_THREADS_MSB:0]     ptr_q, ptr_d;
    logic [N_THREADS_MSB:0]     thread_q, thread_d;
    logic [MEM_ADDR_MSB:0]      addr_q, addr_d;
    logic [SAVE_LEN_W-1:0]      len_q, len_d;
    logic [SAVE_LEN_W-1:0]      issued_q, issued_d;
    logic [SAVE_LEN_W-1:0]      remaining_q, remaining_d;
    logic [1:0]                 credits_q, credits_d;

    logic [MEM_ADDR_MSB:0]      save_addr;
    logic [SAVE_LEN_W-1:0]      save_len;
    logic                       grant_take;
    logic                       data_push;
    logic                       hdr_push;
    logic                       buf_push;
    logic [ENTRY_W-1:0]         buf_din;
    logic [ENTRY_W-1:0]         buf_dout;
    logic                       buf_pop;
    logic                       buf_empty;
    logic                       buf_full;

    function automatic logic [N_THREADS_MSB:0] next_thread(input logic [N_THREADS_MSB:0] t);
        return (t == LAST_THREAD) ? '0 : t + 1'b1;
    endfunction

    assign save_addr   = save_rd[MEM_ADDR_MSB+SAVE_LEN_W:SAVE_LEN_W];
    assign save_len    = save_rd[SAVE_LEN_W-1:0];
    assign ts_rd_num   = ptr_q;
    // ptr_q equals the candidate thread while in CHECK, so it doubles as the lookup index.
    assign save_rd_num = ptr_q;
    assign mem_rd_addr = addr_q;
    assign mem_rd_req  = (state_q == StRead) && (credits_q != 2'd0) && (issued_q != len_q);
    assign grant_take  = mem_rd_req && mem_rd_grant;
    // Responses outside READ/DRAIN are stale (e.g. issued before a reset) and dropped.
    assign data_push   = mem_dout_en && (remaining_q != '0) &&
                         ((state_q == StRead) || (state_q == StDrain));
    assign buf_push    = data_push || hdr_push;
    assign buf_pop     = dout_valid && dout_ready;

    always_comb begin
        buf_din = {(remaining_q == SAVE_LEN_W'(1)), thread_q, mem_dout};
`ifdef RESULT_HEADER_EN
        if (hdr_push) begin
            buf_din = {(save_len == '0), thread_q, header_word(8'(thread_q), 8'(save_len))};
        end
`endif
    end

    md5_result_reader_outbuf #(
        .WIDTH (ENTRY_W)
    ) u_outbuf (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (buf_push),
        .din   (buf_din),
        .pop   (buf_pop),
        .dout  (buf_dout),
        .empty (buf_empty),
        .full  (buf_full)
    );

    assign dout_valid = !buf_empty;
    assign {dout_last, dout_thread, dout} = buf_dout;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        thread_d    = thread_q;
        addr_d      = addr_q;
        len_d       = len_q;
        issued_d    = issued_q;
        remaining_d = remaining_q;
        hdr_push    = 1'b0;
        ts_wr_num   = '0;
        ts_wr       = '0;
        ts_wr_en    = 1'b0;

        if (data_push) begin
            remaining_d = remaining_q - 1'b1;
        end

        unique case (state_q)
            StScan: state_d = StCheck;
            StCheck: begin
                if (ts_rd == THREAD_STATE_WR_RDY) begin
                    thread_d = ptr_q;
                    state_d  = StLookup;
                end else begin
                    ptr_d   = next_thread(ptr_q);
                    state_d = StScan;
                end
            end
            StLookup: begin
                addr_d      = save_addr;
                len_d       = save_len;
                remaining_d = save_len;
                issued_d    = '0;
`ifdef RESULT_HEADER_EN
                // Outbuf is always empty here, so the header has a free slot.
                hdr_push = 1'b1;
                state_d  = (save_len == '0) ? StDrain : StRead;
`else
                state_d  = (save_len == '0) ? StRelease : StRead;
`endif
            end
            StRead: begin
                if (grant_take) begin
                    addr_d   = addr_q + 1'b1;
                    issued_d = issued_q + 1'b1;
                    if (issued_q + 1'b1 == len_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if ((remaining_q == '0) && buf_empty) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                ts_wr_num = thread_q;
                ts_wr     = THREAD_STATE_NONE;
                ts_wr_en  = 1'b1;
                ptr_d     = next_thread(thread_q);
                state_d   = StScan;
            end
            default: state_d = StScan;
        endcase
    end

    // Credits track free outbuf slots not yet promised to an in-flight read or header.
    always_comb begin
        unique case ({grant_take || hdr_push, buf_pop})
            2'b10:   credits_d = credits_q - 2'd1;
            2'b01:   credits_d = credits_q + 2'd1;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StScan;
            ptr_q       <= '0;
            thread_q    <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            remaining_q <= '0;
            credits_q   <= 2'd2;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            thread_q    <= thread_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            remaining_q <= remaining_d;
            credits_q   <= credits_d;
        end
    end

endmodule

// File: tb/tb_md5_result_reader.sv
// Directed bench for md5_result_reader with thread-state, lookup and memory models.
module tb_md5_result_reader;
    import md5_result_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ts_rd_num, ts_wr_num, save_rd_num, dout_thread;
    logic [2:0]  ts_rd = '0, ts_wr;
    logic        ts_wr_en;
    logic [7:0]  save_rd = '0;
    logic        mem_rd_req, mem_rd_grant;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_dout = '0, dout;
    logic        mem_dout_en = 1'b0;
    logic        dout_valid, dout_ready = 1'b1, dout_last;

    always #5 clk = ~clk;

    md5_result_reader dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .ts_rd_num    (ts_rd_num),
        .ts_rd        (ts_rd),
        .ts_wr_num    (ts_wr_num),
        .ts_wr        (ts_wr),
        .ts_wr_en     (ts_wr_en),
        .save_rd_num  (save_rd_num),
        .save_rd      (save_rd),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_grant (mem_rd_grant),
        .mem_dout     (mem_dout),
        .mem_dout_en  (mem_dout_en),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout_last    (dout_last),
        .dout_thread  (dout_thread)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- models ----------------
    logic [2:0]  ts_mem [16] = '{default: 3'd0};
    logic [7:0]  save_tab [16];
    logic [31:0] mem [32];
    logic        set_en = 1'b0;
    logic [3:0]  set_num = '0;
    logic [2:0]  set_val = '0;
    int          lat = 1;
    int          cyc = 0;
    bit          toggle = 1'b0;
    int          rel_q[$];
    int          rel_obs_q[$];
    logic [63:0] obs_q[$];
    int          stall_err = 0;
    int          ovf_err = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;
    resp_t resp_q[$];

    assign mem_rd_grant = mem_rd_req;

    always @(posedge clk) begin
        ts_rd   <= ts_mem[ts_rd_num];
        save_rd <= save_tab[save_rd_num];
        if (set_en) ts_mem[set_num] <= set_val;
        if (ts_wr_en) begin
            ts_mem[ts_wr_num] <= ts_wr;
            rel_q.push_back(int'(ts_wr_num));
            rel_obs_q.push_back(obs_q.size());
        end
    end

    always @(posedge clk) begin
        resp_t r;
        mem_dout_en <= 1'b0;
        if (mem_rd_req && mem_rd_grant) begin
            r.due  = cyc + lat - 1;
            r.data = mem[mem_rd_addr];
            resp_q.push_back(r);
        end
        if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
            mem_dout    <= resp_q[0].data;
            mem_dout_en <= 1'b1;
            void'(resp_q.pop_front());
        end
        cyc <= cyc + 1;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 dout_ready = toggle ? !dout_ready : 1'b1;
        end
    end

    logic [63:0] prev_out = '0;
    bit          stalled_prev = 1'b0;
    always @(negedge clk) begin
        logic [63:0] cur;
        if (rst_n) begin
            cur = 64'({dout_last, dout_thread, dout});
            if (stalled_prev && cur != prev_out) stall_err++;
            stalled_prev = dout_valid && !dout_ready;
            prev_out     = cur;
            if (dout_valid && dout_ready) obs_q.push_back(cur);
            if (dut.u_outbuf.push && dut.u_outbuf.full && !dut.u_outbuf.pop) ovf_err++;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic set_ts(input int num, input logic [2:0] val);
        set_num = 4'(num);
        set_val = val;
        set_en  = 1'b1;
        @(posedge clk);
        #1 set_en = 1'b0;
    endtask

    task automatic build_exp(input int thr, input int addr, input int len,
                             inout logic [63:0] exp_q[$]);
`ifdef RESULT_HEADER_EN
        exp_q.push_back(64'({(len == 0), 4'(thr), 16'h0, 8'(thr), 8'(len)}));
`endif
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(64'({(i == len - 1), 4'(thr), mem[(addr + i) % 32]}));
        end
    endtask

    task automatic wait_rel(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && rel_q.size() < n; i++) @(posedge clk);
        #1 check({tag, "_done"}, 64'(rel_q.size() >= n), 64'd1);
    endtask

    task automatic compare_obs(input string tag, input int ob0, input logic [63:0] exp_q[$]);
        check({tag, "_count"}, 64'(obs_q.size() - ob0), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i),
                  (ob0 + i < obs_q.size()) ? obs_q[ob0 + i] : 64'hdead_dead_dead_dead,
                  exp_q[i]);
        end
    endtask

    task automatic run_one(input string tag, input int thr, input int addr, input int len);
        logic [63:0] exp_q[$];
        int ob0 = obs_q.size();
        int rb0 = rel_q.size();
        save_tab[thr] = {5'(addr), 3'(len)};
        set_ts(thr, THREAD_STATE_WR_RDY);
        wait_rel(tag, rb0 + 1, 400);
        build_exp(thr, addr, len, exp_q);
        compare_obs(tag, ob0, exp_q);
        if (rel_q.size() > rb0) begin
            check({tag, "_rel_thr"}, 64'(rel_q[rb0]), 64'(thr));
            check({tag, "_rel_after_words"}, 64'(rel_obs_q[rb0] - ob0), 64'(exp_q.size()));
        end
        check({tag, "_ts_none"}, 64'(ts_mem[thr]), 64'(THREAD_STATE_NONE));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] exp_q[$];
        int ob0, rb0, ob1;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'hc0de_0000 + 32'(i * 32'h111);
        for (int i = 0; i < 16; i++) save_tab[i] = '0;
        mem[24] = 32'h219e4d5d;
        mem[25] = 32'h84fa9aef;
        mem[26] = 32'h1a6d87e1;
        mem[27] = 32'hffaf0a38;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_dout_last", 64'(dout_last), 64'd0);
        check("rst_ts_wr_en", 64'(ts_wr_en), 64'd0);
        check("rst_mem_rd_req", 64'(mem_rd_req), 64'd0);
        check("rst_ts_rd_num", 64'(ts_rd_num), 64'd0);
        rst_n = 1'b1;

        // 1: basic result, ready always high
        run_one("t1", 0, 24, 4);

        // 2: backpressure and slower memory
        toggle = 1'b1;
        lat    = 3;
        run_one("t2", 0, 24, 4);
        toggle = 1'b0;
        lat    = 1;

        // 3: round-robin wrap from ptr=4
        run_one("t3a", 3, 8, 2);
        ob0 = obs_q.size();
        rb0 = rel_q.size();
        save_tab[11] = {5'd12, 3'd3};
        set_ts(11, THREAD_STATE_WR_RDY);
        set_ts(3, THREAD_STATE_WR_RDY);
        wait_rel("t3b", rb0 + 2, 600);
        exp_q.delete();
        build_exp(11, 12, 3, exp_q);
        build_exp(3, 8, 2, exp_q);
        compare_obs("t3b", ob0, exp_q);
        if (rel_q.size() >= rb0 + 2) begin
            check("t3b_first_rel", 64'(rel_q[rb0]), 64'd11);
            check("t3b_second_rel", 64'(rel_q[rb0 + 1]), 64'd3);
        end
        repeat (40) @(posedge clk);
        #1 check("t3b_no_extra_rel", 64'(rel_q.size()), 64'(rb0 + 2));

        // 4: address wrap and empty result
        run_one("t4", 7, 30, 3);
        run_one("t4z", 8, 0, 0);

        // 5: reset in the middle of a result
        ob0 = obs_q.size();
        rb0 = rel_q.size();
        save_tab[2] = {5'd16, 3'd4};
        set_ts(2, THREAD_STATE_WR_RDY);
        for (int i = 0; i < 400 && obs_q.size() < ob0 + 2; i++) begin
            @(negedge clk);
            #2;
        end
        check("t5_two_words_seen", 64'(obs_q.size() - ob0), 64'd2);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(dout_valid), 64'd0);
        check("t5_rst_dout", 64'(dout), 64'd0);
        check("t5_rst_req", 64'(mem_rd_req), 64'd0);
        check("t5_rst_no_rel", 64'(rel_q.size()), 64'(rb0));
        check("t5_rst_ts_kept", 64'(ts_mem[2]), 64'(THREAD_STATE_WR_RDY));
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        ob1 = obs_q.size();
        wait_rel("t5", rb0 + 1, 400);
        exp_q.delete();
        build_exp(2, 16, 4, exp_q);
        compare_obs("t5", ob1, exp_q);
        if (rel_q.size() > rb0) begin
            check("t5_rel_thr", 64'(rel_q[rb0]), 64'd2);
            check("t5_rel_after_resend", 64'(rel_obs_q[rb0] - ob1), 64'(exp_q.size()));
        end

`ifdef RESULT_HEADER_EN
        // 6: header word layout
        ob0 = obs_q.size();
        run_one("t6", 5, 4, 4);
        check("t6_header", (obs_q.size() > ob0) ? obs_q[ob0] : 64'hdead,
              64'({1'b0, 4'd5, 32'h0000_0504}));
`endif

        check("no_overflow", 64'(ovf_err), 64'd0);
        check("stall_stable", 64'(stall_err), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
